i4004_fetch: RTL and testbench

Instruction-fetch and timing sequencer for the MCS-4 CPU, sitting directly upstream of the i4001 ROMs on the shared 4-bit data bus. It generates the eight-phase instruction cycle and the `sync` pulse, and drives the 12-bit program counter as three address nibbles with `cm_rom`. It captures the OPR/OPA byte (and the second byte of two-word instructions) returned in M1/M2, and hands complete instructions to the execute stage. It owns the PC and the subroutine stack, and resolves JUN/JMS/BBL locally plus JCN/ISZ redirects from an execute-stage taken flag.

---
 rtl/i4004_fetch_if.sv | 34 +++
 rtl/i4004_fetch.sv | 215 +++++++++++++++++++++
 tb/tb_i4004_fetch.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/i4004_fetch_if.sv
// MCS-4 shared types and the fetch-unit bus interface (ROM bus plus instruction hand-off).
package mcs4;
  typedef logic [3:0] char_t;
  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } instr_cyc_t;
endpackage

interface i4004_fetch_if;
  mcs4::char_t      dbus_in;
  mcs4::char_t      dbus_out;
  logic             dbus_oe;
  logic             sync;
  logic             cm_rom;
  mcs4::instr_cyc_t phase;
  logic             instr_valid;
  logic [3:0]       instr_opr;
  logic [3:0]       instr_opa;
  logic [7:0]       instr_arg;
  logic [11:0]      instr_pc;
  logic             branch_taken;

  modport master (
    input  dbus_in, branch_taken,
    output dbus_out, dbus_oe, sync, cm_rom, phase,
           instr_valid, instr_opr, instr_opa, instr_arg, instr_pc
  );

  modport slave (
    output dbus_in, branch_taken,
    input  dbus_out, dbus_oe, sync, cm_rom, phase,
           instr_valid, instr_opr, instr_opa, instr_arg, instr_pc
  );
endinterface

// File: rtl/i4004_fetch.sv
// i4004 instruction fetch / timing sequencer with PC and subroutine stack.
// Define I4004_FETCH_DEEP_STACK_EN for a 7-entry stack (default: 3 entries).
module i4004_fetch
  import mcs4::*;
(
  input  logic          clk,
  input  logic          rst,
  i4004_fetch_if.master bus
);

`ifdef I4004_FETCH_DEEP_STACK_EN
  localparam int unsigned STACK_N = 7;
`else
  localparam int unsigned STACK_N = 3;
`endif
  localparam int unsigned PC_W  = 12;
  localparam int unsigned PTR_W = $clog2(STACK_N);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STACK_N - 1);

  typedef enum logic {W_FIRST, W_SECOND} word_st_t;

  function automatic logic is_two_word(char_t opr, char_t opa);
    case (opr)
      4'h1, 4'h4, 4'h5, 4'h7: return 1'b1;
      4'h2:                   return ~opa[0];
      default:                return 1'b0;
    endcase
  endfunction

  instr_cyc_t       phase_q, phase_d;
  word_st_t         word_q, word_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  char_t            opr_q, opr_d, opa_q, opa_d;
  char_t            first_opr_q, first_opr_d, first_opa_q, first_opa_d;
  logic [PC_W-1:0]  first_pc_q, first_pc_d;
  logic             taken_q, taken_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, pop_idx;
  logic [PC_W-1:0]  stack_q [STACK_N];
  logic             push_c;
  logic             instr_valid_q, instr_valid_d;
  char_t            instr_opr_q, instr_opr_d, instr_opa_q, instr_opa_d;
  logic [7:0]       instr_arg_q, instr_arg_d;
  logic [PC_W-1:0]  instr_pc_q, instr_pc_d;
  char_t            dbus_out_q, dbus_out_d;
  logic             dbus_oe_q, dbus_oe_d, sync_q, sync_d, cm_rom_q, cm_rom_d;

  // State registers: phase counter and word FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_X3;
      word_q  <= W_FIRST;
    end else begin
      phase_q <= phase_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic; the word FSM only moves at the end of X3
  always_comb begin
    phase_d = phase_q;
    word_d  = word_q;
    case (phase_q)
      PH_A1:   phase_d = PH_A2;
      PH_A2:   phase_d = PH_A3;
      PH_A3:   phase_d = PH_M1;
      PH_M1:   phase_d = PH_M2;
      PH_M2:   phase_d = PH_X1;
      PH_X1:   phase_d = PH_X2;
      PH_X2:   phase_d = PH_X3;
      default: phase_d = PH_A1;
    endcase
    if (phase_q == PH_X3) begin
      if (word_q == W_SECOND)                word_d = W_FIRST;
      else if (is_two_word(opr_q, opa_q))    word_d = W_SECOND;
    end
  end

  assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
  assign pop_idx = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);

  // Output / datapath logic: capture, increment, hand-off, redirects, bus drive
  always_comb begin
    pc_d          = pc_q;
    opr_d         = opr_q;
    opa_d         = opa_q;
    first_opr_d   = first_opr_q;
    first_opa_d   = first_opa_q;
    first_pc_d    = first_pc_q;
    taken_d       = taken_q;
    ptr_d         = ptr_q;
    push_c        = 1'b0;
    instr_valid_d = 1'b0;
    instr_opr_d   = instr_opr_q;
    instr_opa_d   = instr_opa_q;
    instr_arg_d   = instr_arg_q;
    instr_pc_d    = instr_pc_q;

    case (phase_q)
      PH_M1: opr_d = bus.dbus_in;
      PH_M2: begin
        opa_d = bus.dbus_in;
        pc_d  = pc_q + PC_W'(1);
        if (word_q == W_SECOND) begin
          instr_valid_d = 1'b1;
          instr_opr_d   = first_opr_q;
          instr_opa_d   = first_opa_q;
          instr_arg_d   = {opr_q, bus.dbus_in};
          instr_pc_d    = first_pc_q;
        end else if (is_two_word(opr_q, bus.dbus_in)) begin
          first_opr_d = opr_q;
          first_opa_d = bus.dbus_in;
          first_pc_d  = pc_q;
        end else begin
          instr_valid_d = 1'b1;
          instr_opr_d   = opr_q;
          instr_opa_d   = bus.dbus_in;
          instr_arg_d   = 8'h00;
          instr_pc_d    = pc_q;
        end
      end
      PH_X2: taken_d = bus.branch_taken;
      PH_X3: begin
        // pc_q already holds the incremented value here
        if (word_q == W_SECOND) begin
          case (first_opr_q)
            4'h4: pc_d = {first_opa_q, opr_q, opa_q};
            4'h5: begin
              push_c = 1'b1;
              ptr_d  = ptr_inc;
              pc_d   = {first_opa_q, opr_q, opa_q};
            end
            4'h1, 4'h7: if (taken_q) pc_d = {pc_q[11:8], opr_q, opa_q};
            default: ;
          endcase
        end else if (opr_q == 4'hC) begin
          pc_d  = stack_q[pop_idx];
          ptr_d = pop_idx;
        end
      end
      default: ;
    endcase

    dbus_oe_d = (phase_d == PH_A1) || (phase_d == PH_A2) || (phase_d == PH_A3);
    sync_d    = (phase_d == PH_X3);
    cm_rom_d  = (phase_d == PH_A3);
    case (phase_d)
      PH_A1:   dbus_out_d = pc_d[3:0];
      PH_A2:   dbus_out_d = pc_d[7:4];
      PH_A3:   dbus_out_d = pc_d[11:8];
      default: dbus_out_d = 4'h0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= '0;
      opr_q         <= '0;
      opa_q         <= '0;
      first_opr_q   <= '0;
      first_opa_q   <= '0;
      first_pc_q    <= '0;
      taken_q       <= 1'b0;
      ptr_q         <= '0;
      instr_valid_q <= 1'b0;
      instr_opr_q   <= '0;
      instr_opa_q   <= '0;
      instr_arg_q   <= '0;
      instr_pc_q    <= '0;
      dbus_out_q    <= '0;
      dbus_oe_q     <= 1'b0;
      sync_q        <= 1'b1;
      cm_rom_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      opr_q         <= opr_d;
      opa_q         <= opa_d;
      first_opr_q   <= first_opr_d;
      first_opa_q   <= first_opa_d;
      first_pc_q    <= first_pc_d;
      taken_q       <= taken_d;
      ptr_q         <= ptr_d;
      instr_valid_q <= instr_valid_d;
      instr_opr_q   <= instr_opr_d;
      instr_opa_q   <= instr_opa_d;
      instr_arg_q   <= instr_arg_d;
      instr_pc_q    <= instr_pc_d;
      dbus_out_q    <= dbus_out_d;
      dbus_oe_q     <= dbus_oe_d;
      sync_q        <= sync_d;
      cm_rom_q      <= cm_rom_d;
    end
  end

  // Circular return stack; pushes the incremented pc
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STACK_N); i++) stack_q[i] <= '0;
    end else if (push_c) begin
      stack_q[ptr_q] <= pc_q;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.dbus_out    = dbus_out_q;
  assign bus.dbus_oe     = dbus_oe_q;
  assign bus.sync        = sync_q;
  assign bus.cm_rom      = cm_rom_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_opr   = instr_opr_q;
  assign bus.instr_opa   = instr_opa_q;
  assign bus.instr_arg   = instr_arg_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_i4004_fetch.sv
// Directed bench for i4004_fetch with a behavioural i4001 ROM on the data bus.
module tb_i4004_fetch;
  import mcs4::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i4004_fetch_if bus();
  i4004_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0]  rom [4096];
  logic [11:0] rom_addr;
  int n_pass  = 0;
  int n_total = 0;

  // ROM: latch address nibbles in A1-A3, return high/low nibble in M1/M2
  always @(posedge clk) begin
    case (bus.phase)
      PH_A1:   rom_addr[3:0]  <= bus.dbus_out;
      PH_A2:   rom_addr[7:4]  <= bus.dbus_out;
      PH_A3:   rom_addr[11:8] <= bus.dbus_out;
      default: ;
    endcase
  end

  always_comb begin
    bus.dbus_in = 4'h0;
    if (bus.phase == PH_M1)      bus.dbus_in = rom[rom_addr][7:4];
    else if (bus.phase == PH_M2) bus.dbus_in = rom[rom_addr][3:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  // Reset for two edges, release, return sampling the first A1
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_total++;
      $error("FAIL %s_timeout observed=no_valid expected=valid", tag);
    end
  endtask

  // Assemble the address driven over the next A1..A3
  task automatic next_fetch(input string tag, output logic [11:0] a);
    int n = 0;
    a = 12'h000;
    @(negedge clk);
    while (bus.phase !== PH_A1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) begin
      n_total++;
      $error("FAIL %s_timeout observed=no_A1 expected=A1", tag);
    end else begin
      a[3:0] = bus.dbus_out;
      @(negedge clk);
      a[7:4] = bus.dbus_out;
      @(negedge clk);
      a[11:8] = bus.dbus_out;
    end
  endtask

  logic [11:0] a;
  int          n;
  logic [11:0] ret_exp [4];

  initial begin
    bus.branch_taken = 1'b0;

    // Reset values and phase / strobe walk on a NOP ROM
    clear_rom();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_phase",  32'(bus.phase), 32'(PH_X3));
    check("rst_sync",   32'(bus.sync), 32'd1);
    check("rst_oe",     32'(bus.dbus_oe), 32'd0);
    check("rst_cm",     32'(bus.cm_rom), 32'd0);
    check("rst_valid",  32'(bus.instr_valid), 32'd0);
    check("rst_dbus",   32'(bus.dbus_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("a1_nibble", 32'(bus.dbus_out), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check("walk_phase", 32'(bus.phase), 32'(k));
      check("walk_cm",    32'(bus.cm_rom), 32'(k == 2));
      check("walk_sync",  32'(bus.sync), 32'(k == 7));
      check("walk_oe",    32'(bus.dbus_oe), 32'(k < 3));
      check("walk_valid", 32'(bus.instr_valid), 32'(k == 5));
      if (k == 5) check("nop_pc", 32'(bus.instr_pc), 32'h000);
      if (k < 7) @(negedge clk);
    end
    next_fetch("nop_next", a);
    check("nop_next", 32'(a), 32'h001);

    // JUN 0x05A: valid only in the second cycle, then redirect
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'h5A;
    bus.branch_taken = 1'b1;
    do_reset();
    wait_valid("jun", n);
    check("jun_latency", 32'(n), 32'd13);
    check("jun_opr", 32'(bus.instr_opr), 32'h4);
    check("jun_opa", 32'(bus.instr_opa), 32'h0);
    check("jun_arg", 32'(bus.instr_arg), 32'h5A);
    check("jun_pc",  32'(bus.instr_pc), 32'h000);
    @(negedge clk);
    check("jun_pulse", 32'(bus.instr_valid), 32'd0);
    check("jun_hold",  32'(bus.instr_arg), 32'h5A);
    next_fetch("jun_next", a);
    check("jun_next", 32'(a), 32'h05A);
    bus.branch_taken = 1'b0;

    // JMS 0x123 at 0x010, BBL returns to 0x012
    clear_rom();
    rom[12'h000] = 8'h40; rom[12'h001] = 8'h10;
    rom[12'h010] = 8'h51; rom[12'h011] = 8'h23;
    rom[12'h123] = 8'hC0;
    do_reset();
    wait_valid("jms_jun", n);
    next_fetch("jms_jun_next", a);
    check("jms_jun_next", 32'(a), 32'h010);
    wait_valid("jms", n);
    check("jms_opr", 32'(bus.instr_opr), 32'h5);
    check("jms_arg", 32'(bus.instr_arg), 32'h23);
    check("jms_pc",  32'(bus.instr_pc), 32'h010);
    next_fetch("jms_next", a);
    check("jms_next", 32'(a), 32'h123);
    wait_valid("bbl", n);
    check("bbl_opr", 32'(bus.instr_opr), 32'hC);
    check("bbl_arg", 32'(bus.instr_arg), 32'h00);
    next_fetch("bbl_next", a);
    check("bbl_next", 32'(a), 32'h012);

    // JCN with second word at 0x0FF, taken and not taken
    for (int t = 0; t < 2; t++) begin
      clear_rom();
      rom[12'h000] = 8'h40; rom[12'h001] = 8'hFE;
      rom[12'h0FE] = 8'h1A; rom[12'h0FF] = 8'h40;
      bus.branch_taken = (t == 0);
      do_reset();
      wait_valid("jcn_jun", n);
      next_fetch("jcn_jun_next", a);
      check("jcn_jun_next", 32'(a), 32'h0FE);
      wait_valid("jcn", n);
      check("jcn_opr", 32'(bus.instr_opr), 32'h1);
      check("jcn_opa", 32'(bus.instr_opa), 32'hA);
      check("jcn_pc",  32'(bus.instr_pc), 32'h0FE);
      next_fetch("jcn_next", a);
      check(t == 0 ? "jcn_taken_next" : "jcn_nottaken_next", 32'(a),
            t == 0 ? 32'h140 : 32'h100);
    end
    bus.branch_taken = 1'b0;

    // Four nested calls then four returns
    clear_rom();
    rom[12'h000] = 8'h51; rom[12'h001] = 8'h00;
    rom[12'h100] = 8'h52; rom[12'h101] = 8'h00;
    rom[12'h200] = 8'h53; rom[12'h201] = 8'h00;
    rom[12'h300] = 8'h54; rom[12'h301] = 8'h00;
    rom[12'h400] = 8'hC0;
    rom[12'h302] = 8'hC0; rom[12'h202] = 8'hC0; rom[12'h102] = 8'hC0;
    ret_exp[0] = 12'h302; ret_exp[1] = 12'h202; ret_exp[2] = 12'h102;
`ifdef I4004_FETCH_DEEP_STACK_EN
    ret_exp[3] = 12'h002;
`else
    ret_exp[3] = 12'h302;
`endif
    do_reset();
    for (int j = 0; j < 4; j++) begin
      wait_valid("call", n);
      next_fetch("call_next", a);
      check("call_next", 32'(a), 32'((j + 1) * 256));
    end
    for (int j = 0; j < 4; j++) begin
      wait_valid("ret", n);
      next_fetch("ret_next", a);
      check("ret_next", 32'(a), 32'(ret_exp[j]));
    end

    // Reset during M2 of a JUN first word
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'h5A;
    do_reset();
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("mid_phase_m2", 32'(bus.phase), 32'(PH_M2));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_phase", 32'(bus.phase), 32'(PH_X3));
    check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_a1", 32'(bus.dbus_out), 32'h0);
    wait_valid("mid_jun", n);
    check("mid_latency", 32'(n), 32'd13);
    check("mid_pc",  32'(bus.instr_pc), 32'h000);
    check("mid_arg", 32'(bus.instr_arg), 32'h5A);
    next_fetch("mid_next", a);
    check("mid_next", 32'(a), 32'h05A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
